enemy_wave_sequencer: RTL and testbench
=======================================

Name: enemy_wave_sequencer

Overview:
Per-frame wave controller that drives the enemy-ship bank's schedule index (ESchedCtr) and tracks which enemies of the current wave are alive. It consumes per-enemy collision pulses from collision logic and sequences idle, intro, run, clear and halt phases. It sits directly upstream of the enemy-ship bank and supplies the schedule counter and alive mask that bank consumes.

Parameters:
NE, 8, number of enemy ships per wave
NM, 16, number of schedule entries per enemy; ESchedCtr range 0..NM-1
STEP_FRAMES, 4, frames per schedule step (>=1)
INTRO_FRAMES, 60, frames spent in INTRO before RUN (>=1)
CLEAR_FRAMES, 120, frames spent in CLEAR before next RUN (>=1)

Ports:
frame_clk  input  1  frame-rate clock; all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  level; sampled each frame; begins or restarts the game
PlayerDead  input  1  level; player ship destroyed this frame
EShipColl  input  NE  per-enemy hit flags for the current frame
ESchedCtr  output  10  schedule index for the enemy-ship bank
EAlive  output  NE  alive mask of the current wave
WaveActive  output  1  high while in RUN
WaveNum  output  4  current wave number, 0-based
WaveCleared  output  1  one-frame pulse when the last enemy dies
KillCount  output  16  total enemies destroyed since game start, saturating
State  output  3  IDLE=0, INTRO=1, RUN=2, CLEAR=3, HALT=4

Behaviour:
- Reset (async, any time, including mid-wave): State=IDLE, ESchedCtr=0, EAlive=0, WaveActive=0, WaveNum=0, WaveCleared=0, KillCount=0, internal StepCnt=0, internal PhaseCnt=0.
- All outputs are registered. Every input takes effect on the frame edge where it is sampled, so outputs change one frame later.
- IDLE: When Start=1, go to INTRO. Load PhaseCnt=0, WaveNum=0, KillCount=0.
- INTRO: PhaseCnt increments each frame. When PhaseCnt==INTRO_FRAMES-1, go to RUN and load EAlive=all ones, ESchedCtr=0, StepCnt=0. Total time in INTRO is exactly INTRO_FRAMES frames.
- RUN: WaveActive=1.
  - StepCnt increments each frame. When StepCnt==STEP_FRAMES-1, StepCnt resets to 0 and ESchedCtr increments.
  - ESchedCtr wraps from NM-1 to 0, so the schedule loops.
- Kills in RUN: for each i with EShipColl[i]=1 and EAlive[i]=1, clear EAlive[i] and add 1 to KillCount, saturating at 16'hFFFF.
  - Several kills in one frame add their popcount.
  - Hits on enemies already dead are ignored.
- Clear detection: if EAlive becomes 0 after the kill update and PlayerDead=0:
  - WaveCleared=1 for exactly that one frame.
  - Go to CLEAR; PhaseCnt=0.
  - WaveNum increments and wraps 15 to 0.
  - ESchedCtr holds.
- PlayerDead=1 in RUN: go to HALT. ESchedCtr freezes. The kill update for that frame still applies. PlayerDead has priority over wave clear: no WaveCleared pulse and WaveNum unchanged.
- CLEAR: WaveActive=0, EAlive=0. PhaseCnt counts. When PhaseCnt==CLEAR_FRAMES-1, go to RUN with EAlive=all ones, ESchedCtr=0, StepCnt=0.
- HALT: All outputs hold and EShipColl is ignored. Start=1 goes to INTRO with WaveNum=0, KillCount=0, EAlive=0, ESchedCtr=0.
- EShipColl is ignored in IDLE, INTRO, CLEAR and HALT.
- PlayerDead is ignored outside RUN.
- Start is ignored outside IDLE and HALT.
- WaveCleared is 0 in every frame except the clear frame.

Test Plan:
- NE=4, NM=4, STEP_FRAMES=2, INTRO_FRAMES=3, CLEAR_FRAMES=5. Reset, then Start=1 for one frame:
  - State=INTRO for 3 frames, then RUN with EAlive=4'b1111.
  - ESchedCtr sequence 0,0,1,1,2,2,3,3,0 (wraps).
- In RUN, EShipColl=4'b0101 for one frame:
  - EAlive=4'b1010 and KillCount=2.
  - Repeating 4'b0101 next frame leaves KillCount=2.
- In RUN with EAlive=4'b0010, EShipColl=4'b0010:
  - WaveCleared pulses for 1 frame, WaveNum 0 to 1, State=CLEAR.
  - After 5 frames State=RUN, EAlive=4'b1111, ESchedCtr=0.
- In RUN with EAlive=4'b0001, EShipColl=4'b0001 and PlayerDead=1 in the same frame:
  - State=HALT, EAlive=0, KillCount incremented by 1.
  - WaveCleared stays 0, WaveNum unchanged, ESchedCtr frozen.
- From HALT, Start=1: State=INTRO, WaveNum=0, KillCount=0.
- Assert Reset mid-RUN between frame edges: all outputs go to reset values immediately, without waiting for a frame_clk edge.

Source files
------------

// File: rtl/enemy_wave_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : enemy_wave_sequencer
// Brief    : Per-frame wave controller. Drives the enemy schedule index and the
//            alive mask, counts kills, and sequences the idle, intro, run,
//            clear and halt phases.
// Revision : 1.0 - initial release
// ============================================================================
module enemy_wave_sequencer #(
  parameter int NE           = 8,
  parameter int NM           = 16,
  parameter int STEP_FRAMES  = 4,
  parameter int INTRO_FRAMES = 60,
  parameter int CLEAR_FRAMES = 120
) (
  input  logic          frame_clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          PlayerDead,
  input  logic [NE-1:0] EShipColl,
  output logic [9:0]    ESchedCtr,
  output logic [NE-1:0] EAlive,
  output logic          WaveActive,
  output logic [3:0]    WaveNum,
  output logic          WaveCleared,
  output logic [15:0]   KillCount,
  output logic [2:0]    State
);

  localparam int c_PHASE_MAX = (INTRO_FRAMES > CLEAR_FRAMES) ? INTRO_FRAMES : CLEAR_FRAMES;
  localparam int c_PHASE_W   = (c_PHASE_MAX > 1) ? $clog2(c_PHASE_MAX) : 1;
  localparam int c_STEP_W    = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam int c_CNT_W     = $clog2(NE + 1);

  localparam logic [c_PHASE_W-1:0] c_INTRO_LAST = c_PHASE_W'(INTRO_FRAMES - 1);
  localparam logic [c_PHASE_W-1:0] c_CLEAR_LAST = c_PHASE_W'(CLEAR_FRAMES - 1);
  localparam logic [c_PHASE_W-1:0] c_PHASE_ONE  = c_PHASE_W'(1);
  localparam logic [c_STEP_W-1:0]  c_STEP_LAST  = c_STEP_W'(STEP_FRAMES - 1);
  localparam logic [c_STEP_W-1:0]  c_STEP_ONE   = c_STEP_W'(1);
  localparam logic [9:0]           c_SCHED_LAST = 10'(NM - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INTRO = 3'd1,
    S_RUN   = 3'd2,
    S_CLEAR = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t                r_state, w_stateNext;
  logic [c_PHASE_W-1:0]  r_phaseCnt, w_phaseNext;
  logic [c_STEP_W-1:0]   r_stepCnt, w_stepNext;
  logic [9:0]            w_schedNext;
  logic [NE-1:0]         w_aliveNext, w_aliveAfter, w_hits;
  logic [3:0]            w_waveNumNext;
  logic [15:0]           w_killNext, w_killSat;
  logic [16:0]           w_killSum;
  logic [c_CNT_W-1:0]    w_hitCount;
  logic                  w_clearedNext;

  assign State = r_state;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_phaseCnt  <= '0;
      r_stepCnt   <= '0;
      ESchedCtr   <= '0;
      EAlive      <= '0;
      WaveActive  <= 1'b0;
      WaveNum     <= '0;
      WaveCleared <= 1'b0;
      KillCount   <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_phaseCnt  <= w_phaseNext;
      r_stepCnt   <= w_stepNext;
      ESchedCtr   <= w_schedNext;
      EAlive      <= w_aliveNext;
      WaveActive  <= (w_stateNext == S_RUN);
      WaveNum     <= w_waveNumNext;
      WaveCleared <= w_clearedNext;
      KillCount   <= w_killNext;
    end
  end

  always_comb begin
    w_hits       = EShipColl & EAlive;
    w_aliveAfter = EAlive & ~EShipColl;
    w_hitCount   = '0;
    for (int i = 0; i < NE; i++) begin
      w_hitCount = w_hitCount + c_CNT_W'(w_hits[i]);
    end
    w_killSum = {1'b0, KillCount} + 17'(w_hitCount);
    w_killSat = w_killSum[16] ? 16'hFFFF : w_killSum[15:0];

    w_stateNext   = r_state;
    w_phaseNext   = r_phaseCnt;
    w_stepNext    = r_stepCnt;
    w_schedNext   = ESchedCtr;
    w_aliveNext   = EAlive;
    w_waveNumNext = WaveNum;
    w_killNext    = KillCount;
    w_clearedNext = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_stateNext   = S_INTRO;
          w_phaseNext   = '0;
          w_waveNumNext = '0;
          w_killNext    = '0;
        end
      end
      S_INTRO: begin
        if (r_phaseCnt == c_INTRO_LAST) begin
          w_stateNext = S_RUN;
          w_aliveNext = '1;
          w_schedNext = '0;
          w_stepNext  = '0;
        end else begin
          w_phaseNext = r_phaseCnt + c_PHASE_ONE;
        end
      end
      S_RUN: begin
        w_aliveNext = w_aliveAfter;
        w_killNext  = w_killSat;
        // A player death outranks a wave clear landing on the same frame.
        if (PlayerDead) begin
          w_stateNext = S_HALT;
        end else if (w_aliveAfter == '0) begin
          w_stateNext   = S_CLEAR;
          w_phaseNext   = '0;
          w_clearedNext = 1'b1;
          w_waveNumNext = WaveNum + 4'd1;
        end else if (r_stepCnt == c_STEP_LAST) begin
          w_stepNext  = '0;
          w_schedNext = (ESchedCtr == c_SCHED_LAST) ? 10'd0 : ESchedCtr + 10'd1;
        end else begin
          w_stepNext = r_stepCnt + c_STEP_ONE;
        end
      end
      S_CLEAR: begin
        w_aliveNext = '0;
        if (r_phaseCnt == c_CLEAR_LAST) begin
          w_stateNext = S_RUN;
          w_aliveNext = '1;
          w_schedNext = '0;
          w_stepNext  = '0;
        end else begin
          w_phaseNext = r_phaseCnt + c_PHASE_ONE;
        end
      end
      S_HALT: begin
        if (Start) begin
          w_stateNext   = S_INTRO;
          w_phaseNext   = '0;
          w_waveNumNext = '0;
          w_killNext    = '0;
          w_aliveNext   = '0;
          w_schedNext   = '0;
        end
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_enemy_wave_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_enemy_wave_sequencer
// Brief    : Directed bench for enemy_wave_sequencer with a small configuration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enemy_wave_sequencer;

  logic        frame_clk;
  logic        Reset;
  logic        Start;
  logic        PlayerDead;
  logic [3:0]  EShipColl;
  logic [9:0]  ESchedCtr;
  logic [3:0]  EAlive;
  logic        WaveActive;
  logic [3:0]  WaveNum;
  logic        WaveCleared;
  logic [15:0] KillCount;
  logic [2:0]  State;

  int checks = 0;
  int errors = 0;

  enemy_wave_sequencer #(
    .NE(4), .NM(4), .STEP_FRAMES(2), .INTRO_FRAMES(3), .CLEAR_FRAMES(5)
  ) dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .Start      (Start),
    .PlayerDead (PlayerDead),
    .EShipColl  (EShipColl),
    .ESchedCtr  (ESchedCtr),
    .EAlive     (EAlive),
    .WaveActive (WaveActive),
    .WaveNum    (WaveNum),
    .WaveCleared(WaveCleared),
    .KillCount  (KillCount),
    .State      (State)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one frame edge and settle just after it.
  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  initial begin
    int schedExp[8];
    schedExp = '{0, 1, 1, 2, 2, 3, 3, 0};

    Reset = 1'b1; Start = 1'b0; PlayerDead = 1'b0; EShipColl = 4'b0000;
    #12;
    check("rst_state",   32'(State), 0);
    check("rst_sched",   32'(ESchedCtr), 0);
    check("rst_alive",   32'(EAlive), 0);
    check("rst_active",  32'(WaveActive), 0);
    check("rst_wavenum", 32'(WaveNum), 0);
    check("rst_cleared", 32'(WaveCleared), 0);
    check("rst_kills",   32'(KillCount), 0);
    Reset = 1'b0;
    step();
    check("idle_hold", 32'(State), 0);

    // Intro lasts three frames, then the wave starts.
    Start = 1'b1;
    step();
    Start = 1'b0;
    check("intro_f0", 32'(State), 1);
    step();
    check("intro_f1", 32'(State), 1);
    step();
    check("intro_f2", 32'(State), 1);
    step();
    check("run_state",  32'(State), 2);
    check("run_alive",  32'(EAlive), 'hF);
    check("run_active", 32'(WaveActive), 1);
    check("run_sched0", 32'(ESchedCtr), 0);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("sched_seq%0d", i), 32'(ESchedCtr), 32'(schedExp[i]));
    end

    // Two kills, then the same hits on now-dead ships.
    EShipColl = 4'b0101;
    step();
    check("kill_alive", 32'(EAlive), 'hA);
    check("kill_count", 32'(KillCount), 2);
    step();
    check("rehit_alive", 32'(EAlive), 'hA);
    check("rehit_count", 32'(KillCount), 2);
    check("rehit_sched", 32'(ESchedCtr), 1);
    EShipColl = 4'b1000;
    step();
    check("kill3_alive", 32'(EAlive), 'h2);
    check("kill3_count", 32'(KillCount), 3);

    // Last enemy falls: wave clear.
    EShipColl = 4'b0010;
    step();
    EShipColl = 4'b0000;
    check("clr_pulse",   32'(WaveCleared), 1);
    check("clr_wavenum", 32'(WaveNum), 1);
    check("clr_state",   32'(State), 3);
    check("clr_alive",   32'(EAlive), 0);
    check("clr_kills",   32'(KillCount), 4);
    check("clr_active",  32'(WaveActive), 0);
    check("clr_sched",   32'(ESchedCtr), 1);
    EShipColl = 4'b1111;
    step();
    check("clr_pulse_end", 32'(WaveCleared), 0);
    check("clr_ignore_kills", 32'(KillCount), 4);
    for (int i = 1; i < 4; i++) begin
      step();
      check($sformatf("clr_hold%0d", i), 32'(State), 3);
    end
    EShipColl = 4'b0000;
    step();
    check("rerun_state", 32'(State), 2);
    check("rerun_alive", 32'(EAlive), 'hF);
    check("rerun_sched", 32'(ESchedCtr), 0);
    check("rerun_active", 32'(WaveActive), 1);

    // Final kill coincides with player death: halt, no clear.
    EShipColl = 4'b1110;
    step();
    check("pre_halt_alive", 32'(EAlive), 'h1);
    check("pre_halt_kills", 32'(KillCount), 7);
    EShipColl = 4'b0001; PlayerDead = 1'b1;
    step();
    EShipColl = 4'b1111; PlayerDead = 1'b0;
    check("halt_state",   32'(State), 4);
    check("halt_alive",   32'(EAlive), 0);
    check("halt_kills",   32'(KillCount), 8);
    check("halt_cleared", 32'(WaveCleared), 0);
    check("halt_wavenum", 32'(WaveNum), 1);
    check("halt_sched",   32'(ESchedCtr), 0);
    step();
    step();
    check("halt_hold_state", 32'(State), 4);
    check("halt_hold_kills", 32'(KillCount), 8);
    check("halt_hold_wave",  32'(WaveNum), 1);
    EShipColl = 4'b0000;

    // Restart from halt.
    Start = 1'b1;
    step();
    Start = 1'b0;
    check("restart_state", 32'(State), 1);
    check("restart_wave",  32'(WaveNum), 0);
    check("restart_kills", 32'(KillCount), 0);
    check("restart_alive", 32'(EAlive), 0);
    step();
    step();
    step();
    check("restart_run", 32'(State), 2);
    EShipColl = 4'b0011;
    step();
    EShipColl = 4'b0000;
    step();
    check("pre_rst_kills", 32'(KillCount), 2);
    check("pre_rst_sched", 32'(ESchedCtr), 1);

    // Asynchronous reset between frame edges.
    Reset = 1'b1;
    #1;
    check("arst_state",  32'(State), 0);
    check("arst_sched",  32'(ESchedCtr), 0);
    check("arst_alive",  32'(EAlive), 0);
    check("arst_active", 32'(WaveActive), 0);
    check("arst_kills",  32'(KillCount), 0);
    check("arst_wave",   32'(WaveNum), 0);
    #5;
    Reset = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
